// File: rtl/slice_op_pkg.sv
// Shared types and field-index helpers for the slice-operation pipeline.
// Optional feature macro used by the top: SLICE_OP_PARITY_EN.
package slice_op_pkg;

    typedef enum logic [1:0] {
        MODE_STD  = 2'b00,
        MODE_XNOR = 2'b01,
        MODE_PASS = 2'b10,
        MODE_ACC  = 2'b11
    } mode_t;

    // Low bit of the first XOR operand field.
    function automatic int xor_a_lo();
        return 1;
    endfunction

    // Low bit of the second XOR operand field.
    function automatic int xor_b_lo(input int xor_w);
        return xor_w + 1;
    endfunction

    // Low bit of the invert source field.
    function automatic int inv_lo(input int xor_w);
        return 2 * xor_w + 1;
    endfunction

    // True when all source fields fit the input word and all result fields fit the output word.
    function automatic bit fields_fit(input int in_w, input int out_w, input int xor_w, input int inv_w);
        return (2 * xor_w + inv_w + 1 <= in_w) && (xor_w + inv_w <= out_w);
    endfunction

endpackage

// File: rtl/slice_op_pipe_if.sv
// Input and output stream handshakes of the slice-operation pipeline.
// slave is the pipeline side, master is the producer/consumer side.
interface slice_op_pipe_if
    import slice_op_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    mode_t            in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/slice_op_fifo.sv
// Count-based output FIFO. When empty the head output holds the last popped word
// (zero after reset), so the consumer never sees stale storage contents.
module slice_op_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] hold_q;

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and last-popped word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            hold_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
                hold_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign head = (level != '0) ? mem[rd_ptr] : hold_q;

endmodule

// File: rtl/slice_op_pipe.sv
// Two-stage slice-operation pipeline: stage 1 registers the accepted word, stage 2
// computes the XOR/invert/XNOR/pass/accumulate result straight into the output FIFO.
// Define SLICE_OP_PARITY_EN to add the out_parity port (^out_data).
module slice_op_pipe
    import slice_op_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10,
    parameter int XOR_W = 2,
    parameter int INV_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    slice_op_pipe_if.slave             bus,
    input  logic                       acc_clr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [CNT_W-1:0]           word_cnt
`ifdef SLICE_OP_PARITY_EN
    ,
    output logic                       out_parity
`endif
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [OUT_W-1:0] XOR_MASK = OUT_W'((1 << XOR_W) - 1);

    if (!fields_fit(IN_W, OUT_W, XOR_W, INV_W) || DEPTH < 1) begin : g_bad_params
        $fatal(1, "slice_op_pipe: field widths do not fit IN_W/OUT_W or DEPTH < 1");
    end

    logic             vld_p1;
    logic [IN_W-1:0]  data_p1;
    mode_t            mode_p1;
    logic             adv_p1;
    logic             accept;
    logic             pop;
    logic [OUT_W-1:0] std_res;
    logic [OUT_W-1:0] res_p2;
    logic [OUT_W-1:0] acc_q;
    logic             unused_data_bits;

    assign pop          = bus.out_valid & bus.out_ready;
    assign adv_p1       = vld_p1 & ((fifo_level < DEPTH_L) | pop);
    assign bus.in_ready = rst_n & (!vld_p1 | adv_p1);
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (fifo_level != '0);

    // Upper input bits only matter in some modes; keep them visibly consumed.
    assign unused_data_bits = ^data_p1;

    // ---- stage 1: input register ----

    // Stage-1 occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage-1 word and mode, captured on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= bus.in_data;
            mode_p1 <= bus.in_mode;
        end
    end

    // ---- stage 2: compute into FIFO ----

    // Result selection; ACC clears before applying when acc_clr coincides.
    always_comb begin
        std_res = '0;
        for (int i = 0; i < XOR_W; i++) begin
            std_res[i] = data_p1[xor_a_lo() + i] ^ data_p1[xor_b_lo(XOR_W) + i];
        end
        for (int j = 0; j < INV_W; j++) begin
            std_res[XOR_W + j] = ~data_p1[inv_lo(XOR_W) + j];
        end
        res_p2 = std_res;
        unique case (mode_p1)
            MODE_STD:  res_p2 = std_res;
            MODE_XNOR: res_p2 = std_res ^ XOR_MASK;
            MODE_PASS: res_p2 = data_p1[OUT_W-1:0];
            MODE_ACC:  res_p2 = (acc_clr ? '0 : acc_q) ^ std_res;
            default:   res_p2 = std_res;
        endcase
    end

    // Running accumulator: follows ACC words entering the FIFO, or clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (adv_p1 && mode_p1 == MODE_ACC) begin
            acc_q <= res_p2;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

    // Saturating count of popped words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (pop && word_cnt != '1) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    slice_op_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (adv_p1),
        .push_data (res_p2),
        .pop       (pop),
        .head      (bus.out_data),
        .level     (fifo_level)
    );

`ifdef SLICE_OP_PARITY_EN
    assign out_parity = ^bus.out_data;
`endif

endmodule

// File: tb/tb_slice_op_pipe.sv
// Directed bench for slice_op_pipe with default parameters.
// Define SLICE_OP_PARITY_EN to also check out_parity.
module tb_slice_op_pipe;
    import slice_op_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        acc_clr;
    logic [1:0]  fifo_level;
    logic [15:0] word_cnt;
`ifdef SLICE_OP_PARITY_EN
    logic        out_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    slice_op_pipe_if #(.IN_W(20), .OUT_W(10)) bus ();

    slice_op_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .acc_clr    (acc_clr),
        .fifo_level (fifo_level),
        .word_cnt   (word_cnt)
`ifdef SLICE_OP_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word through an empty pipe with out_ready=1: accept, enter FIFO, pop.
    task automatic send_one(input string tag, input logic [19:0] d, input mode_t m,
                            input logic clr, input logic [9:0] exp);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        acc_clr      = clr;
        check({tag, ":valid_s1"}, 32'(bus.out_valid), 32'd0);
        tick();
        acc_clr = 1'b0;
        check({tag, ":valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ":data"}, 32'(bus.out_data), 32'(exp));
`ifdef SLICE_OP_PARITY_EN
        check({tag, ":parity"}, 32'(out_parity), 32'(^exp));
`endif
        tick();
        check({tag, ":empty"}, 32'(bus.out_valid), 32'd0);
        check({tag, ":hold"}, 32'(bus.out_data), 32'(exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        acc_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = MODE_STD;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("rst:out_data", 32'(bus.out_data), 32'd0);
        check("rst:level", 32'(fifo_level), 32'd0);
        check("rst:word_cnt", 32'(word_cnt), 32'd0);
        check("rst:in_ready", 32'(bus.in_ready), 32'd0);
`ifdef SLICE_OP_PARITY_EN
        check("rst:parity", 32'(out_parity), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("rel:in_ready", 32'(bus.in_ready), 32'd1);

        // Basic modes
        send_one("std", 20'h0014C, MODE_STD, 1'b0, 10'h017);
        check("std:word_cnt", 32'(word_cnt), 32'd1);
        send_one("xnor", 20'h0014C, MODE_XNOR, 1'b0, 10'h014);
        send_one("pass", 20'h0014C, MODE_PASS, 1'b0, 10'h14C);

        // Accumulate and clear interactions
        send_one("acc1", 20'h0014C, MODE_ACC, 1'b0, 10'h017);
        send_one("acc2", 20'h0014C, MODE_ACC, 1'b0, 10'h000);
        send_one("acc3", 20'h0014C, MODE_ACC, 1'b0, 10'h017);
        send_one("acc_clr_same", 20'h0014C, MODE_ACC, 1'b1, 10'h017);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        send_one("acc_after_clr", 20'h0014C, MODE_ACC, 1'b0, 10'h017);
        send_one("pass_clr", 20'h0014C, MODE_PASS, 1'b1, 10'h14C);
        check("acc:word_cnt", 32'(word_cnt), 32'd9);

        // Backpressure: three words accepted, fourth held
        bus.out_ready = 1'b0;
        bus.in_mode   = MODE_PASS;
        bus.in_valid  = 1'b1;
        bus.in_data   = 20'h00001;
        tick();
        bus.in_data = 20'h00002;
        tick();
        bus.in_data = 20'h00003;
        tick();
        bus.in_data = 20'h00004;
        check("bp:level", 32'(fifo_level), 32'd2);
        check("bp:in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check("bp:level_hold", 32'(fifo_level), 32'd2);
        check("bp:in_ready_hold", 32'(bus.in_ready), 32'd0);
        check("bp:head", 32'(bus.out_data), 32'h001);
        check("bp:word_cnt", 32'(word_cnt), 32'd9);
        bus.out_ready = 1'b1;
        #1;
        check("bp:in_ready_pop", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp:full_pop_level", 32'(fifo_level), 32'd2);
        check("bp:w2", 32'(bus.out_data), 32'h002);
        tick();
        check("bp:w3", 32'(bus.out_data), 32'h003);
        tick();
        check("bp:w4", 32'(bus.out_data), 32'h004);
        check("bp:level1", 32'(fifo_level), 32'd1);
        tick();
        check("bp:drained", 32'(bus.out_valid), 32'd0);
        check("bp:hold", 32'(bus.out_data), 32'h004);
        check("bp:word_cnt_end", 32'(word_cnt), 32'd13);

        // Reset with a full FIFO and stage 1 occupied
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 20'h00055;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("mr:level_full", 32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mr:in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mr:out_valid", 32'(bus.out_valid), 32'd0);
        check("mr:level", 32'(fifo_level), 32'd0);
        check("mr:word_cnt", 32'(word_cnt), 32'd0);
        check("mr:in_ready", 32'(bus.in_ready), 32'd1);
        check("mr:out_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        send_one("post_rst", 20'h0014C, MODE_STD, 1'b0, 10'h017);
        check("post_rst:word_cnt", 32'(word_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
